alu_exec_unit: RTL and testbench

- Execute-stage ALU that consumes the 3-bit ALU control code from the ALU control decoder, plus two 16-bit operands from the register-read stage.
- Produces a registered result and flags (zero for BEQ/BNE) towards writeback and branch logic.
- ADD/SUB/NOT/AND/OR take one cycle. Shifts are iterative, one bit per cycle.
- valid/ready handshakes on both sides let the control path stall on multi-cycle shifts.

---
 rtl/alu_exec_unit_pkg.sv | 27 ++
 rtl/alu_exec_unit_comb.sv | 54 +++++
 rtl/alu_exec_unit.sv | 160 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the execute-stage ALU: control encodings, FSM states
// and a small decode helper. The ALU control decoder imports the same package.
package alu_exec_unit_pkg;

  // ALU control encodings (3-bit code from the ALU control decoder)
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_NOT  = 3'b010;
  localparam logic [2:0] ALU_SLL  = 3'b011;
  localparam logic [2:0] ALU_SRL  = 3'b100;
  localparam logic [2:0] ALU_AND  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_PASS = 3'b111;

  // Execute-unit FSM states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // True for the two iterative shift operations
  function automatic logic is_shift_op(input logic [2:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_exec_unit_comb.sv
// Single-cycle ALU datapath: ADD/SUB/NOT/AND/OR/PASS with carry and signed
// overflow. SLL/SRL fall through to op_a, which is the correct result for a
// zero shift amount; non-zero shifts are handled iteratively by the top level.
module alu_comb
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] sub_sum;
  logic           sign_a;
  logic           sign_b;

  // Subtraction is A + ~B + 1 so that carry-out means "no borrow"
  assign add_sum = {1'b0, op_a} + {1'b0, op_b};
  assign sub_sum = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
  assign sign_a  = op_a[WIDTH-1];
  assign sign_b  = op_b[WIDTH-1];

  // Select the operation result; carry/overflow are only meaningful for ADD/SUB
  always_comb begin
    y        = op_a;
    carry    = 1'b0;
    overflow = 1'b0;
    case (ctrl)
      ALU_ADD: begin
        y        = add_sum[WIDTH-1:0];
        carry    = add_sum[WIDTH];
        // Same-sign operands producing a different-sign sum
        overflow = (sign_a == sign_b) && (add_sum[WIDTH-1] != sign_a);
      end
      ALU_SUB: begin
        y        = sub_sum[WIDTH-1:0];
        carry    = sub_sum[WIDTH];
        // Opposite-sign operands where the difference flips away from A's sign
        overflow = (sign_a != sign_b) && (sub_sum[WIDTH-1] != sign_a);
      end
      ALU_NOT:  y = ~op_a;
      ALU_AND:  y = op_a & op_b;
      ALU_OR:   y = op_a | op_b;
      ALU_PASS: y = op_a;
      default:  y = op_a;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes. Single-cycle ops complete on
// the accept edge; SLL/SRL shift one bit per cycle in a work register and only
// publish the final value, so result/flags never show intermediate shifts.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     work;
  logic [SHAMT_W-1:0]   cnt;
  logic                 shift_right;

  logic                 accept;
  logic [SHAMT_W-1:0]   shamt;
  logic                 iter_shift;
  logic                 single_step;
  logic [WIDTH-1:0]     first_shift;
  logic [WIDTH-1:0]     next_work;
  logic                 last_step;

  logic [WIDTH-1:0]     comb_y;
  logic                 comb_carry;
  logic                 comb_overflow;

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .ctrl     (ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .y        (comb_y),
    .carry    (comb_carry),
    .overflow (comb_overflow)
  );

  // Upper op_b bits are ignored for shifts; a zero amount takes the 1-cycle path
  assign shamt       = op_b[SHAMT_W-1:0];
  assign iter_shift  = is_shift_op(ctrl) && (shamt != '0);
  assign single_step = (shamt == CNT_ONE);
  assign first_shift = (ctrl == ALU_SRL) ? (op_a >> 1) : (op_a << 1);
  assign next_work   = shift_right ? (work >> 1) : (work << 1);
  assign last_step   = (cnt == CNT_ONE);

  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_HOLD);

  // Ready is held low in reset and only follows out_ready while holding a result
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      case (state)
        S_IDLE:  in_ready = 1'b1;
        S_HOLD:  in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  // Next-state logic: accept from IDLE/HOLD, count down in SHIFT, drain HOLD
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = (iter_shift && !single_step) ? S_SHIFT : S_HOLD;
        end
      end
      S_SHIFT: begin
        if (last_step) begin
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (accept) begin
          state_next = (iter_shift && !single_step) ? S_SHIFT : S_HOLD;
        end else if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Shift work register and remaining-step counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work        <= '0;
      cnt         <= '0;
      shift_right <= 1'b0;
    end else if (accept) begin
      if (iter_shift) begin
        work        <= first_shift;
        cnt         <= shamt - CNT_ONE;
        shift_right <= (ctrl == ALU_SRL);
      end
    end else if (state == S_SHIFT) begin
      work <= next_work;
      cnt  <= cnt - CNT_ONE;
    end
  end

  // Output registers: loaded on a 1-cycle accept or on the final shift step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      if (iter_shift) begin
        if (single_step) begin
          result   <= first_shift;
          zero     <= (first_shift == '0);
          carry    <= 1'b0;
          overflow <= 1'b0;
        end
      end else begin
        result   <= comb_y;
        zero     <= (comb_y == '0);
        carry    <= comb_carry;
        overflow <= comb_overflow;
      end
    end else if ((state == S_SHIFT) && last_step) begin
      result   <= next_work;
      zero     <= (next_work == '0);
      carry    <= 1'b0;
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit: hand-computed vectors for each op,
// shift latency, backpressure, back-to-back issue and mid-operation reset.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ctrl;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero;
  logic        carry;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(
    .WIDTH   (16),
    .SHAMT_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl      (ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge
  task automatic go;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; ctrl = 3'b000;
    op_a = 16'h0; op_b = 16'h0; out_ready = 1'b0;
    #3;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h want 0000", result); end
    checks++;
    if ({zero, carry, overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {zero, carry, overflow}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    go;
  endtask

  task automatic test_add;
    in_valid = 1'b1; ctrl = 3'b000; op_a = 16'h7FFF; op_b = 16'h0001; out_ready = 1'b1;
    go;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency: out_valid %b want 1", out_valid); end
    checks++;
    if (result !== 16'h8000) begin errors++; $display("FAIL add_result: got %h want 8000", result); end
    checks++;
    if ({zero, carry, overflow} !== 3'b001) begin errors++; $display("FAIL add_flags: zco got %b want 001", {zero, carry, overflow}); end
    go;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_sub;
    in_valid = 1'b1; ctrl = 3'b001; op_a = 16'h0005; op_b = 16'h0005; out_ready = 1'b1;
    go;
    op_a = 16'h0003; op_b = 16'h0005;
    checks++;
    if (result !== 16'h0000) begin errors++; $display("FAIL sub_eq_result: got %h want 0000", result); end
    checks++;
    if ({zero, carry, overflow} !== 3'b110) begin errors++; $display("FAIL sub_eq_flags: zco got %b want 110", {zero, carry, overflow}); end
    go;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 16'hFFFE) begin errors++; $display("FAIL sub_lt_result: got vld %b %h want 1 fffe", out_valid, result); end
    checks++;
    if ({zero, carry, overflow} !== 3'b000) begin errors++; $display("FAIL sub_lt_flags: zco got %b want 000", {zero, carry, overflow}); end
    go;
  endtask

  task automatic test_shift(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b,
                            input int n, input logic [15:0] expv, input string name);
    int bad;
    in_valid = 1'b1; ctrl = c; op_a = a; op_b = b; out_ready = 1'b1;
    go;
    in_valid = 1'b0;
    bad = 0;
    for (int i = 1; i < n; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
      go;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s_busy: %0d early/ready cycles want 0", name, bad); end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_latency: out_valid %b want 1 after %0d cycles", name, out_valid, n); end
    checks++;
    if (result !== expv) begin errors++; $display("FAIL %s_result: got %h want %h", name, result, expv); end
    checks++;
    if ({zero, carry, overflow} !== {(expv == 16'h0), 2'b00}) begin
      errors++; $display("FAIL %s_flags: zco got %b want %b", name, {zero, carry, overflow}, {(expv == 16'h0), 2'b00});
    end
    go;
  endtask

  task automatic test_back_to_back;
    in_valid = 1'b1; ctrl = 3'b101; op_a = 16'hF0F0; op_b = 16'h0FF0; out_ready = 1'b0;
    go;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== 16'h00F0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_%0d: vld %b res %h rdy %b want 1 00f0 0", i, out_valid, result, in_ready);
      end
      go;
    end
    in_valid = 1'b1; ctrl = 3'b110; op_a = 16'h1200; op_b = 16'h0034; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
    go;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 16'h1234) begin errors++; $display("FAIL b2b_result: vld %b res %h want 1 1234", out_valid, result); end
    go;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_shift;
    int bad;
    in_valid = 1'b1; ctrl = 3'b011; op_a = 16'h0001; op_b = 16'h000A; out_ready = 1'b1;
    go;
    in_valid = 1'b0;
    go;
    go;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_busy: out_valid %b want 0", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_hs: rdy %b vld %b want 0 0", in_ready, out_valid); end
    checks++;
    if (result !== 16'h0000 || {zero, carry, overflow} !== 3'b000) begin
      errors++; $display("FAIL midrst_outputs: res %h zco %b want 0000 000", result, {zero, carry, overflow});
    end
    go;
    rst_n = 1'b1;
    go;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_release: rdy %b vld %b want 1 0", in_ready, out_valid); end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0) bad++;
      go;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midrst_stale: %0d out_valid cycles want 0", bad); end
  endtask

  task automatic test_not_pass;
    in_valid = 1'b1; ctrl = 3'b010; op_a = 16'hFFFF; op_b = 16'h1234; out_ready = 1'b1;
    go;
    ctrl = 3'b111; op_a = 16'hABCD; op_b = 16'hFFFF;
    checks++;
    if (result !== 16'h0000 || {zero, carry, overflow} !== 3'b100) begin
      errors++; $display("FAIL not_result: res %h zco %b want 0000 100", result, {zero, carry, overflow});
    end
    go;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 16'hABCD || {zero, carry, overflow} !== 3'b000) begin
      errors++; $display("FAIL pass_result: vld %b res %h zco %b want 1 abcd 000", out_valid, result, {zero, carry, overflow});
    end
    go;
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_shift(3'b011, 16'h0001, 16'h000F, 15, 16'h8000, "sll15");
    test_shift(3'b100, 16'h8000, 16'h0004, 4,  16'h0800, "srl4");
    test_shift(3'b011, 16'h0001, 16'h0010, 1,  16'h0001, "sll0");
    test_shift(3'b100, 16'h0001, 16'h0001, 1,  16'h0000, "srl1_zero");
    test_back_to_back;
    test_reset_mid_shift;
    test_not_pass;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
